// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master bus arbiter with split/resume handling and a hold-time limit.
// A master that is split by the slave is parked and can never be granted
// until the slave resumes it. A resumed master gets priority at its next
// arbitration. A grant that has been held for MAX_HOLD cycles while the other
// master is eligible is revoked. That revocation is flagged by a one-cycle
// timeout pulse.
//
// Every change of ownership passes through one IDLE cycle. All outputs are
// decoded from registered state, so a grant rises one clock after the request
// is sampled in IDLE.
//
// Parameters
//   MAX_HOLD     grant hold limit in cycles while the other master waits
//                (legal range 2..31; the hold counter is 5 bits wide)
//
// Configuration macro
//   ROUND_ROBIN_EN  defined   : a tie with no resume priority goes to the
//                               master that did not own the bus last
//                   undefined : a tie with no resume priority always goes to
//                               master1; there is no last-owner register
//
// Ports
//   clk                  in   rising-edge clock
//   reset                in   synchronous, active-high reset
//   m1_request           in   master1 wants the bus (held for the transaction)
//   m2_request           in   master2 wants the bus (held for the transaction)
//   split                in   one-cycle pulse: split the current owner
//   m1_resume            in   one-cycle pulse: parked master1 may re-arbitrate
//   m2_resume            in   one-cycle pulse: parked master2 may re-arbitrate
//   m1_grant             out  master1 owns the bus
//   m2_grant             out  master2 owns the bus
//   owner[1:0]           out  00 none, 01 master1, 10 master2
//   m1_parked            out  master1 held off by a pending split
//   m2_parked            out  master2 held off by a pending split
//   timeout              out  one-cycle pulse after a grant is revoked
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic       split,
    input  logic       m1_resume,
    input  logic       m2_resume,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic [1:0] owner,
    output logic       m1_parked,
    output logic       m2_parked,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT1 = 2'd1;
    localparam logic [1:0] ST_GRANT2 = 2'd2;

    // Last counter value before the hold limit is reached.
    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    logic [1:0] state_q,    state_d;
    logic [4:0] hold_cnt_q, hold_cnt_d;
    logic       parked1_q,  parked1_d;
    logic       parked2_q,  parked2_d;
    logic       prio1_q,    prio1_d;
    logic       prio2_q,    prio2_d;
    logic       timeout_q,  timeout_d;
`ifdef ROUND_ROBIN_EN
    // 1: master2 owned the bus last, 0: master1 did.
    logic       last2_q,    last2_d;
`endif

    logic elig1;
    logic elig2;
    logic tie_to_m1;
    logic pick1;
    logic hold_full;

    assign elig1     = m1_request & ~parked1_q;
    assign elig2     = m2_request & ~parked2_q;
    assign hold_full = (hold_cnt_q == HOLD_LAST);

`ifdef ROUND_ROBIN_EN
    assign tie_to_m1 = last2_q;
`else
    assign tie_to_m1 = 1'b1;
`endif

    // Master1 wins IDLE arbitration if it is eligible and either alone, or
    // holds the only resume-priority flag, or wins the plain tie rule.
    always_comb begin
        pick1 = 1'b0;
        if (elig1 && !elig2) begin
            pick1 = 1'b1;
        end else if (elig1 && elig2) begin
            if (prio1_q && !prio2_q) begin
                pick1 = 1'b1;
            end else if (prio2_q && !prio1_q) begin
                pick1 = 1'b0;
            end else begin
                pick1 = tie_to_m1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        parked1_d  = parked1_q;
        parked2_d  = parked2_q;
        prio1_d    = prio1_q;
        prio2_d    = prio2_q;
        timeout_d  = 1'b0;
`ifdef ROUND_ROBIN_EN
        last2_d    = last2_q;
`endif

        // A resume only matters to a master that is actually parked.
        if (m1_resume && parked1_q) begin
            parked1_d = 1'b0;
            prio1_d   = 1'b1;
        end
        if (m2_resume && parked2_q) begin
            parked2_d = 1'b0;
            prio2_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick1) begin
                    state_d    = ST_GRANT1;
                    hold_cnt_d = 5'd0;
                    prio1_d    = 1'b0;
`ifdef ROUND_ROBIN_EN
                    last2_d    = 1'b0;
`endif
                end else if (elig2) begin
                    state_d    = ST_GRANT2;
                    hold_cnt_d = 5'd0;
                    prio2_d    = 1'b0;
`ifdef ROUND_ROBIN_EN
                    last2_d    = 1'b1;
`endif
                end
            end

            ST_GRANT1: begin
                // Split takes precedence over a simultaneous request drop.
                if (split) begin
                    state_d   = ST_IDLE;
                    parked1_d = 1'b1;
                end else if (!m1_request) begin
                    state_d = ST_IDLE;
                end else if (hold_full && elig2) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
`ifdef ROUND_ROBIN_EN
                    last2_d   = 1'b0;
`endif
                end else if (!hold_full) begin
                    hold_cnt_d = hold_cnt_q + 5'd1;
                end
            end

            ST_GRANT2: begin
                if (split) begin
                    state_d   = ST_IDLE;
                    parked2_d = 1'b1;
                end else if (!m2_request) begin
                    state_d = ST_IDLE;
                end else if (hold_full && elig1) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
`ifdef ROUND_ROBIN_EN
                    last2_d   = 1'b1;
`endif
                end else if (!hold_full) begin
                    hold_cnt_d = hold_cnt_q + 5'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 5'd0;
            parked1_q  <= 1'b0;
            parked2_q  <= 1'b0;
            prio1_q    <= 1'b0;
            prio2_q    <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last2_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            parked1_q  <= parked1_d;
            parked2_q  <= parked2_d;
            prio1_q    <= prio1_d;
            prio2_q    <= prio2_d;
            timeout_q  <= timeout_d;
`ifdef ROUND_ROBIN_EN
            last2_q    <= last2_d;
`endif
        end
    end

    assign m1_grant  = (state_q == ST_GRANT1);
    assign m2_grant  = (state_q == ST_GRANT2);
    assign owner     = {m2_grant, m1_grant};
    assign m1_parked = parked1_q;
    assign m2_parked = parked2_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    // Stimulus row bits: {reset, m1_request, m2_request, split, m1_resume, m2_resume}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_RST  = 6'b100000;
    localparam logic [5:0] S_R1   = 6'b010000;
    localparam logic [5:0] S_R2   = 6'b001000;
    localparam logic [5:0] S_R12  = 6'b011000;
    localparam logic [5:0] S_SP   = 6'b000100;
    localparam logic [5:0] S_RS1  = 6'b000010;
    localparam logic [5:0] S_RS2  = 6'b000001;

    // Expected output bits: {m1_grant, m2_grant, owner[1:0], m1_parked, m2_parked, timeout}
    localparam logic [6:0] E_N    = 7'b0000000;
    localparam logic [6:0] E_G1   = 7'b1001000;
    localparam logic [6:0] E_G2   = 7'b0110000;
    localparam logic [6:0] E_TO   = 7'b0000001;
    localparam logic [6:0] E_P1   = 7'b0000100;
    localparam logic [6:0] E_P2   = 7'b0000010;
    localparam logic [6:0] E_P12  = 7'b0000110;
    localparam logic [6:0] E_G2P1 = 7'b0110100;
`ifdef ROUND_ROBIN_EN
    localparam logic [6:0] E_ALT  = E_G2;
`else
    localparam logic [6:0] E_ALT  = E_G1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request;
    logic       m2_request;
    logic       split;
    logic       m1_resume;
    logic       m2_resume;
    logic       m1_grant;
    logic       m2_grant;
    logic [1:0] owner;
    logic       m1_parked;
    logic       m2_parked;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q [$];

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .m1_request (m1_request),
        .m2_request (m2_request),
        .split      (split),
        .m1_resume  (m1_resume),
        .m2_resume  (m2_resume),
        .m1_grant   (m1_grant),
        .m2_grant   (m2_grant),
        .owner      (owner),
        .m1_parked  (m1_parked),
        .m2_parked  (m2_parked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] observe();
        return {m1_grant, m2_grant, owner, m1_parked, m2_parked, timeout};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic apply(input logic [5:0] s, input logic [6:0] e);
        {reset, m1_request, m2_request, split, m1_resume, m2_resume} = s;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [5:0] stim [2];
        logic [6:0] expv [2];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST | S_R12, S_RST | S_R12 | S_SP};
        expv = '{E_N, E_N};
        for (int i = 0; i < 2; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_single();
        logic [5:0] stim [6];
        logic [6:0] expv [6];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_R1, S_R1, S_NONE, S_NONE, S_R2, S_NONE};
        expv = '{E_G1, E_G1, E_N, E_N, E_G2, E_N};
        for (int i = 0; i < 6; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL single[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    // Lone master keeps the bus past MAX_HOLD; a late competitor revokes it at once.
    task automatic test_hold_saturate();
        logic [5:0] stim [11];
        logic [6:0] expv [11];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST, S_R1, S_R1, S_R1, S_R1, S_R1, S_R1, S_R1, S_R12, S_R2, S_NONE};
        expv = '{E_N, E_G1, E_G1, E_G1, E_G1, E_G1, E_G1, E_G1, E_TO, E_G2, E_N};
        for (int i = 0; i < 11; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL hold_saturate[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [5:0] stim [14];
        logic [6:0] expv [14];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST, S_R12, S_R12, S_R12, S_R12, S_R12, S_R12, S_R12, S_R12, S_R12,
                 S_R12, S_R12, S_NONE, S_NONE};
        expv = '{E_N, E_G1, E_G1, E_G1, E_G1, E_TO, E_ALT, E_ALT, E_ALT, E_ALT,
                 E_TO, E_G1, E_N, E_N};
        for (int i = 0; i < 14; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_split_resume();
        logic [5:0] stim [10];
        logic [6:0] expv [10];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST, S_R1, S_R1 | S_SP, S_R12, S_R12, S_R12 | S_RS1, S_R12, S_R12,
                 S_R12, S_NONE};
        expv = '{E_N, E_G1, E_P1, E_G2P1, E_G2P1, E_G2, E_G2, E_TO, E_G1, E_N};
        for (int i = 0; i < 10; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL split_resume[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    // Resume priority overrides both tie rules and is consumed by the grant.
    task automatic test_resume_priority();
        logic [5:0] stim [9];
        logic [6:0] expv [9];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST, S_R2, S_R2 | S_SP, S_R2, S_R2 | S_RS2, S_R12, S_NONE, S_R12, S_NONE};
        expv = '{E_N, E_G2, E_P2, E_P2, E_N, E_G2, E_N, E_G1, E_N};
        for (int i = 0; i < 9; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL resume_priority[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    // Split in IDLE ignored; split with a simultaneous request drop still parks.
    task automatic test_split_drop();
        logic [5:0] stim [8];
        logic [6:0] expv [8];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST, S_SP, S_R1, S_SP, S_R1 | S_RS2, S_R12, S_R2 | S_RS1, S_NONE};
        expv = '{E_N, E_N, E_G1, E_P1, E_P1, E_G2P1, E_G2, E_N};
        for (int i = 0; i < 8; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL split_drop[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    // Ends with master2 granted and master1 parked.
    task automatic test_both_parked();
        logic [5:0] stim [9];
        logic [6:0] expv [9];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST, S_R1, S_R1 | S_SP, S_R12, S_R12 | S_SP, S_R12, S_R12,
                 S_R12 | S_RS2, S_R12};
        expv = '{E_N, E_G1, E_P1, E_G2P1, E_P12, E_P12, E_P12, E_P1, E_G2P1};
        for (int i = 0; i < 9; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL both_parked[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] stim [4];
        logic [6:0] expv [4];
        logic [6:0] want;
        logic [6:0] got;
        stim = '{S_RST | S_R12, S_R12, S_R12, S_NONE};
        expv = '{E_N, E_G1, E_G1, E_N};
        for (int i = 0; i < 4; i++) begin
            apply(stim[i], expv[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = observe();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    initial begin
        {reset, m1_request, m2_request, split, m1_resume, m2_resume} = S_RST;
        test_reset();
        test_single();
        test_hold_saturate();
        test_timeout();
        test_split_resume();
        test_resume_priority();
        test_split_drop();
        test_both_parked();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got checks %0d required completion", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
